// File: rtl/lvt_multiport_ram.sv
// Multi-port RAM (P_NUM_RD read / P_NUM_WR write ports) built from replicated write banks
// plus a live-value table; clears itself after reset and flags same-address write collisions.
module lvt_multiport_ram #(
    parameter int unsigned              P_MEM_DEPTH  = 16,
    parameter int unsigned              P_MEM_WIDTH  = 32,
    parameter int unsigned              P_NUM_RD     = 2,
    parameter int unsigned              P_NUM_WR     = 2,
    parameter logic [P_MEM_WIDTH-1:0]   P_INIT_VALUE = {P_MEM_WIDTH{1'b0}}
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n_i,
    input  logic [P_NUM_RD*$clog2(P_MEM_DEPTH)-1:0]     rd_addr_i,
    output logic [P_NUM_RD*P_MEM_WIDTH-1:0]             rd_data_o,
    input  logic [P_NUM_WR*$clog2(P_MEM_DEPTH)-1:0]     wr_addr_i,
    input  logic [P_NUM_WR*P_MEM_WIDTH-1:0]             wr_data_i,
    input  logic [P_NUM_WR-1:0]                         wr_valid_i,
    output logic                                        init_busy_o,
    output logic                                        wr_conflict_o
);

    localparam int unsigned IDX   = $clog2(P_MEM_DEPTH);
    localparam int unsigned LVT_W = (P_NUM_WR > 1) ? $clog2(P_NUM_WR) : 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     state_next_s;
    logic [IDX-1:0]             cnt_r;
    logic                       sweep_s;
    logic                       run_s;
    logic                       busy_next_s;
    logic                       init_busy_r;
    logic                       wr_conflict_r;
    logic [P_MEM_WIDTH-1:0]     rd_data_r    [P_NUM_RD];

    logic [IDX-1:0]             rd_addr_s    [P_NUM_RD];
    logic [IDX-1:0]             wr_addr_s    [P_NUM_WR];
    logic [P_MEM_WIDTH-1:0]     wr_data_s    [P_NUM_WR];
    logic [P_NUM_WR-1:0]        win_s;
    logic                       conflict_s;
    logic [P_NUM_WR-1:0]        bank_we_s;
    logic [IDX-1:0]             bank_addr_s  [P_NUM_WR];
    logic [P_MEM_WIDTH-1:0]     bank_wdata_s [P_NUM_WR];
    logic [P_NUM_WR*P_NUM_RD*P_MEM_WIDTH-1:0] bank_q_s;
    logic [LVT_W-1:0]           lvt_q_s      [P_NUM_RD];
    logic [P_MEM_WIDTH-1:0]     rd_next_s    [P_NUM_RD];

    // Unpack the flat address/data buses into per-port arrays
    always_comb begin
        for (int k = 0; k < P_NUM_RD; k++) begin
            rd_addr_s[k] = rd_addr_i[k*IDX +: IDX];
        end
        for (int j = 0; j < P_NUM_WR; j++) begin
            wr_addr_s[j] = wr_addr_i[j*IDX +: IDX];
            wr_data_s[j] = wr_data_i[j*P_MEM_WIDTH +: P_MEM_WIDTH];
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: leave INIT once the last entry has been swept
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: state_next_s = (cnt_r == IDX'(P_MEM_DEPTH - 1)) ? ST_RUN : ST_INIT;
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_INIT;
        endcase
    end

    // FSM outputs
    always_comb begin
        sweep_s = 1'b0;
        run_s   = 1'b0;
        case (state_r)
            ST_INIT: sweep_s = 1'b1;
            ST_RUN:  run_s   = 1'b1;
            default: begin
                sweep_s = 1'b0;
                run_s   = 1'b0;
            end
        endcase
        busy_next_s = (state_next_s == ST_INIT);
    end

    // Lowest-index valid port owns an address; any higher-index hit is a collision
    always_comb begin
        win_s      = '0;
        conflict_s = 1'b0;
        for (int j = 0; j < P_NUM_WR; j++) begin
            win_s[j] = run_s & wr_valid_i[j];
            for (int i = 0; i < j; i++) begin
                win_s[j]   = win_s[j] & ~(wr_valid_i[i] & (wr_addr_s[i] == wr_addr_s[j]));
                conflict_s = conflict_s |
                             (run_s & wr_valid_i[i] & wr_valid_i[j] & (wr_addr_s[i] == wr_addr_s[j]));
            end
        end
    end

    // Bank write ports; bank 0 is borrowed by the clearing sweep
    always_comb begin
        for (int j = 0; j < P_NUM_WR; j++) begin
            bank_we_s[j]    = win_s[j];
            bank_addr_s[j]  = wr_addr_s[j];
            bank_wdata_s[j] = wr_data_s[j];
        end
        if (sweep_s) begin
            bank_we_s[0]    = 1'b1;
            bank_addr_s[0]  = cnt_r;
            bank_wdata_s[0] = P_INIT_VALUE;
        end else begin
            bank_we_s[0]    = win_s[0];
        end
    end

    for (genvar j = 0; j < P_NUM_WR; j++) begin : g_bank
        for (genvar k = 0; k < P_NUM_RD; k++) begin : g_rep
            logic [P_MEM_WIDTH-1:0] mem_r [P_MEM_DEPTH];

            // One replica per read port so every port gets its own read path
            always_ff @(posedge clk_i) begin
                if (bank_we_s[j]) begin
                    mem_r[bank_addr_s[j]] <= bank_wdata_s[j];
                end
            end

            assign bank_q_s[(j*P_NUM_RD+k)*P_MEM_WIDTH +: P_MEM_WIDTH] = mem_r[rd_addr_s[k]];
        end
    end

    if (P_NUM_WR > 1) begin : g_lvt
        logic [LVT_W-1:0] lvt_r [P_MEM_DEPTH];

        // Winning ports always target distinct addresses, so their updates never overlap
        always_ff @(posedge clk_i) begin
            for (int j = 0; j < P_NUM_WR; j++) begin
                if (bank_we_s[j]) begin
                    lvt_r[bank_addr_s[j]] <= LVT_W'(j);
                end
            end
        end

        // LVT lookup per read port
        always_comb begin
            for (int k = 0; k < P_NUM_RD; k++) begin
                lvt_q_s[k] = lvt_r[rd_addr_s[k]];
            end
        end
    end else begin : g_no_lvt
        // Single write port: bank 0 is always live
        always_comb begin
            for (int k = 0; k < P_NUM_RD; k++) begin
                lvt_q_s[k] = '0;
            end
        end
    end

    // Read select: live bank, overridden by a same-cycle winning write (lowest port applied last)
    always_comb begin
        for (int k = 0; k < P_NUM_RD; k++) begin
            rd_next_s[k] = '0;
            for (int j = 0; j < P_NUM_WR; j++) begin
                rd_next_s[k] = (lvt_q_s[k] == LVT_W'(j)) ?
                               bank_q_s[(j*P_NUM_RD+k)*P_MEM_WIDTH +: P_MEM_WIDTH] : rd_next_s[k];
            end
            for (int j = P_NUM_WR - 1; j >= 0; j--) begin
                rd_next_s[k] = (win_s[j] && (wr_addr_s[j] == rd_addr_s[k])) ?
                               wr_data_s[j] : rd_next_s[k];
            end
        end
    end

    // Sweep counter, status flags and registered read data
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r         <= '0;
            init_busy_r   <= 1'b1;
            wr_conflict_r <= 1'b0;
            for (int k = 0; k < P_NUM_RD; k++) begin
                rd_data_r[k] <= '0;
            end
        end else begin
            cnt_r         <= sweep_s ? (cnt_r + 1'b1) : cnt_r;
            init_busy_r   <= busy_next_s;
            wr_conflict_r <= conflict_s;
            for (int k = 0; k < P_NUM_RD; k++) begin
                rd_data_r[k] <= rd_next_s[k];
            end
        end
    end

    // Pack registered read data onto the output bus
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < P_NUM_RD; k++) begin
            rd_data_o[k*P_MEM_WIDTH +: P_MEM_WIDTH] = rd_data_r[k];
        end
    end

    assign init_busy_o   = init_busy_r;
    assign wr_conflict_o = wr_conflict_r;

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Directed checks on a 16x32 2R2W instance, then randomized traffic on a 32x32 4R3W
// instance compared against a flat-array reference model.
module tb_lvt_multiport_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 16 x 32, 2R/2W
    logic        rst_a;
    logic [7:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [7:0]  wr_addr_a;
    logic [63:0] wr_data_a;
    logic [1:0]  wr_valid_a;
    logic        busy_a;
    logic        conf_a;

    // Instance B: 32 x 32, 4R/3W
    logic         rst_b;
    logic [19:0]  rd_addr_b;
    logic [127:0] rd_data_b;
    logic [14:0]  wr_addr_b;
    logic [95:0]  wr_data_b;
    logic [2:0]   wr_valid_b;
    logic         busy_b;
    logic         conf_b;

    lvt_multiport_ram #(
        .P_MEM_DEPTH(16), .P_MEM_WIDTH(32), .P_NUM_RD(2), .P_NUM_WR(2), .P_INIT_VALUE(32'h0)
    ) dut_a (
        .clk_i(clk), .rst_n_i(rst_a),
        .rd_addr_i(rd_addr_a), .rd_data_o(rd_data_a),
        .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a), .wr_valid_i(wr_valid_a),
        .init_busy_o(busy_a), .wr_conflict_o(conf_a)
    );

    lvt_multiport_ram #(
        .P_MEM_DEPTH(32), .P_MEM_WIDTH(32), .P_NUM_RD(4), .P_NUM_WR(3), .P_INIT_VALUE(32'h0)
    ) dut_b (
        .clk_i(clk), .rst_n_i(rst_b),
        .rd_addr_i(rd_addr_b), .rd_data_o(rd_data_b),
        .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b), .wr_valid_i(wr_valid_b),
        .init_busy_o(busy_b), .wr_conflict_o(conf_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Counts negedge samples with busy high, bounded so a stuck flag cannot hang the run
    task automatic count_busy(input bit sel_b, output int n);
        n = 0;
        while ((sel_b ? busy_b : busy_a) && (n < 80)) begin
            n++;
            @(negedge clk);
        end
    endtask

    logic [31:0] model [32];
    logic [4:0]  wa [3];
    logic [31:0] wd [3];
    logic        wv [3];
    logic [4:0]  ra [4];
    logic [31:0] exp_rd [4];
    logic        exp_conf;
    bit          found;
    int          n;

    initial begin
        rst_a = 1'b0; rd_addr_a = '0; wr_addr_a = '0; wr_data_a = '0; wr_valid_a = '0;
        rst_b = 1'b0; rd_addr_b = '0; wr_addr_b = '0; wr_data_b = '0; wr_valid_b = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("a_reset_rd", 64'(rd_data_a), 64'h0);
        chk("a_reset_conf", 64'(conf_a), 64'h0);
        chk("a_reset_busy", 64'(busy_a), 64'h1);

        // Sweep length and cleared contents
        rst_a = 1'b1;
        count_busy(1'b0, n);
        chk("a_busy_len", 64'(n), 64'd16);
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = {4'(15 - a), 4'(a)};
            @(negedge clk);
            chk($sformatf("a_sweep_rd0_%0d", a), 64'(rd_data_a[31:0]), 64'h0);
            chk($sformatf("a_sweep_rd1_%0d", 15 - a), 64'(rd_data_a[63:32]), 64'h0);
        end

        // Later write from port 1 supersedes earlier write from port 0
        wr_addr_a = {4'd0, 4'd3}; wr_data_a = {32'h0, 32'hDEADBEEF}; wr_valid_a = 2'b01;
        @(negedge clk);
        wr_addr_a = {4'd3, 4'd0}; wr_data_a = {32'h12345678, 32'h0}; wr_valid_a = 2'b10;
        @(negedge clk);
        wr_valid_a = 2'b00; rd_addr_a = {4'd3, 4'd3};
        @(negedge clk);
        chk("a_lvt_rd0", 64'(rd_data_a[31:0]), 64'h12345678);
        chk("a_lvt_rd1", 64'(rd_data_a[63:32]), 64'h12345678);

        // Same-address collision: port 0 wins, flag pulses once
        wr_addr_a = {4'd5, 4'd5}; wr_data_a = {32'h5555FFFF, 32'hAAAA0000}; wr_valid_a = 2'b11;
        rd_addr_a = {4'd0, 4'd5};
        @(negedge clk);
        chk("a_coll_fwd", 64'(rd_data_a[31:0]), 64'hAAAA0000);
        chk("a_coll_flag", 64'(conf_a), 64'h1);
        wr_valid_a = 2'b00; rd_addr_a = {4'd5, 4'd3};
        @(negedge clk);
        chk("a_coll_flag_drop", 64'(conf_a), 64'h0);
        chk("a_coll_stored", 64'(rd_data_a[63:32]), 64'hAAAA0000);
        chk("a_addr3_keep", 64'(rd_data_a[31:0]), 64'h12345678);

        // Write-first forwarding on both ports, distinct addresses do not collide
        wr_addr_a = {4'd9, 4'd1}; wr_data_a = {32'h00000009, 32'h00000011}; wr_valid_a = 2'b11;
        rd_addr_a = {4'd9, 4'd1};
        @(negedge clk);
        chk("a_fwd_rd1", 64'(rd_data_a[63:32]), 64'h9);
        chk("a_fwd_rd0", 64'(rd_data_a[31:0]), 64'h11);
        chk("a_no_coll", 64'(conf_a), 64'h0);

        wr_addr_a = {4'd0, 4'd2}; wr_data_a = {32'h0, 32'hCAFE0002}; wr_valid_a = 2'b01;
        @(negedge clk);
        wr_valid_a = 2'b00; rd_addr_a = {4'd9, 4'd2};
        @(negedge clk);
        chk("a_addr2", 64'(rd_data_a[31:0]), 64'hCAFE0002);
        chk("a_addr9", 64'(rd_data_a[63:32]), 64'h9);

        // Asynchronous reset from RUN clears outputs immediately
        #2 rst_a = 1'b0;
        #1 chk("a_rst_run_rd", 64'(rd_data_a), 64'h0);
        chk("a_rst_run_busy", 64'(busy_a), 64'h1);
        @(negedge clk);
        rst_a = 1'b1;

        // Reset again at sweep cycle 7, while port 1 still sees stale addr 9
        repeat (7) @(negedge clk);
        #2 rst_a = 1'b0;
        #1 chk("a_rst_sweep_rd", 64'(rd_data_a), 64'h0);
        chk("a_rst_sweep_busy", 64'(busy_a), 64'h1);
        chk("a_rst_sweep_conf", 64'(conf_a), 64'h0);
        @(negedge clk);
        rst_a = 1'b1;
        count_busy(1'b0, n);
        chk("a_busy_len2", 64'(n), 64'd16);
        rd_addr_a = {4'd9, 4'd2};
        @(negedge clk);
        chk("a_lost_addr2", 64'(rd_data_a[31:0]), 64'h0);
        chk("a_lost_addr9", 64'(rd_data_a[63:32]), 64'h0);
        rd_addr_a = {4'd3, 4'd5};
        @(negedge clk);
        chk("a_lost_addr5", 64'(rd_data_a[31:0]), 64'h0);
        chk("a_lost_addr3", 64'(rd_data_a[63:32]), 64'h0);

        // Randomized traffic on the 4R/3W instance
        rst_b = 1'b1;
        count_busy(1'b1, n);
        chk("b_busy_len", 64'(n), 64'd32);
        for (int i = 0; i < 32; i++) begin
            model[i] = 32'h0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int j = 0; j < 3; j++) begin
                wa[j] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                wd[j] = $urandom;
                wv[j] = ($urandom_range(0, 9) < 6);
                wr_addr_b[j*5 +: 5]   = wa[j];
                wr_data_b[j*32 +: 32] = wd[j];
                wr_valid_b[j]         = wv[j];
            end
            for (int k = 0; k < 4; k++) begin
                ra[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                rd_addr_b[k*5 +: 5] = ra[k];
            end
            // Expected read: first valid writer to the address, else stored value
            for (int k = 0; k < 4; k++) begin
                found     = 1'b0;
                exp_rd[k] = model[ra[k]];
                for (int j = 0; j < 3; j++) begin
                    if (!found && wv[j] && (wa[j] == ra[k])) begin
                        exp_rd[k] = wd[j];
                        found     = 1'b1;
                    end
                end
            end
            exp_conf = 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = i + 1; j < 3; j++) begin
                    if (wv[i] && wv[j] && (wa[i] == wa[j])) begin
                        exp_conf = 1'b1;
                    end
                end
            end
            for (int j = 2; j >= 0; j--) begin
                if (wv[j]) begin
                    model[wa[j]] = wd[j];
                end
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("b_rd%0d_cyc%0d", k, c), 64'(rd_data_b[k*32 +: 32]), 64'(exp_rd[k]));
            end
            chk($sformatf("b_conf_cyc%0d", c), 64'(conf_b), 64'(exp_conf));
        end
        wr_valid_b = '0;
        chk("b_busy_run", 64'(busy_b), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lvt_multiport_ram.md
Name: lvt_multiport_ram

Overview:
- Parametrised nR/mW synchronous RAM: P_NUM_RD read ports, P_NUM_WR write ports, all addresses independent.
- Single-clock successor to the 2R2W multipumped/banked RAM.
- Built as P_NUM_WR write banks, each replicated P_NUM_RD times, plus a Live-Value Table (LVT) that records which bank last wrote each entry.
- Adds a post-reset clearing sweep, deterministic write-collision priority and a collision flag. Serves as the register-file/scoreboard store for the VP pipeline.

Parameters:
P_MEM_DEPTH, 16, number of entries; power of two, >= 2
P_MEM_WIDTH, 32, data bits per entry
P_NUM_RD, 2, read ports, 1..8
P_NUM_WR, 2, write ports, 1..4
P_INIT_VALUE, 0, value written to every entry by the reset sweep

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_n_i  in  1  asynchronous active-low reset
rd_addr_i  in  P_NUM_RD*IDX  packed read addresses, port k at [k*IDX +: IDX], IDX=$clog2(P_MEM_DEPTH)
rd_data_o  out  P_NUM_RD*P_MEM_WIDTH  packed registered read data
wr_addr_i  in  P_NUM_WR*IDX  packed write addresses
wr_data_i  in  P_NUM_WR*P_MEM_WIDTH  packed write data
wr_valid_i  in  P_NUM_WR  per-port write enable
init_busy_o  out  1  high while the clearing sweep runs; writes are ignored while high
wr_conflict_o  out  1  registered pulse: two or more valid writes hit the same address in the previous cycle

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - rd_data_o=0, wr_conflict_o=0, init_busy_o=1.
  - FSM goes to INIT; sweep counter=0.
- FSM states:
  - INIT: each cycle writes P_INIT_VALUE into entry cnt of bank 0 (all read replicas) and sets LVT[cnt]=0; cnt increments.
  - INIT to RUN when cnt==P_MEM_DEPTH-1 has been written; the sweep takes exactly P_MEM_DEPTH cycles after reset release.
  - init_busy_o is registered and drops in the first RUN cycle.
  - RUN is terminal until the next reset.
- During INIT:
  - wr_valid_i is ignored and wr_conflict_o stays 0.
  - Reads still operate; entries not yet swept return undefined data. The bench must not check reads while init_busy_o=1.
- RUN write:
  - A valid port j writes wr_data_j into bank j, all P_NUM_RD replicas, at wr_addr_j.
  - LVT[wr_addr_j] is set to j.
- Write collision:
  - Valid writes from ports i<j to the same address: the lowest-index port wins. Only its data is visible afterwards and the LVT records it.
  - wr_conflict_o=1 in the following cycle only. Different-address writes never collide.
- Read latency: 1 cycle. rd_data_o[k] at edge t+1 reflects rd_addr_k sampled at edge t.
- Read/write same cycle, same address (write-first forwarding):
  - rd_data_o[k] returns the data of the winning write port, i.e. the lowest-index valid port matching rd_addr_k.
  - Otherwise it returns the bank selected by the LVT for that address.
- Multiple read ports on the same address return identical data.
- Addresses are always in range (power-of-two depth); no wrap or error handling.
- Reset mid-operation: contents are treated as lost, outputs clear immediately and the sweep restarts from entry 0.
- P_NUM_WR=1: the LVT degenerates to width 0 and is removed; behaviour is otherwise identical.
- Reference model: a single flat array with the priority/forwarding rules above. The DUT must match it bit-exactly on every cycle with init_busy_o=0.

Test Plan:
- Reset, then release for 1 cycle -> init_busy_o high for exactly 16 cycles. Afterwards every read of addresses 0..15 on all ports returns 0x00000000 (P_INIT_VALUE=0).
- In RUN:
  - write port0 addr3=0xDEADBEEF;
  - next cycle write port1 addr3=0x12345678;
  - then read addr3 on ports 0 and 1.
  -> both ports return 0x12345678; the LVT picks bank 1.
- Same cycle: port0 and port1 both write addr5 (0xAAAA0000 and 0x5555FFFF), with rd_addr port0=5 -> rd_data port0=0xAAAA0000 next cycle; wr_conflict_o=1 for exactly one cycle; a later read of addr5 still returns 0xAAAA0000.
- Write port1 addr9=0x00000009 while reading addr9 on port1 in the same cycle -> forwarded 0x00000009 at latency 1, not the old value 0.
- Assert rst_n_i low at sweep cycle 7, release, then wait -> outputs are 0 immediately on assertion; the sweep restarts and init_busy_o stays high for 16 more cycles; an earlier write to addr2 is lost and it reads 0.
- Randomised 10k cycles with P_NUM_RD=4, P_NUM_WR=3, depth 32 and random addresses/valids -> zero mismatches against the reference model. wr_conflict_o matches a model-computed collision flag on every cycle.
